brick_field: RTL and testbench

BRICK_FIELD -- requirements
Module: brick_field

---
 rtl/brick_field.sv | 193 +++++++++++++++++++
 tb/tb_brick_field.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/brick_field.sv
// rtl/brick_field.sv - Breakout brick wall: per-frame ball/brick collision scan and brick state.
//
// Purpose: keeps the alive flags of a fixed 2 x 11 brick wall. On every frame
// event it latches the ball bounding box and walks the bricks one per clock.
// It reports a 2-bit bounce code for the first alive brick the ball overlaps.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_ani_stb, i_animate  frame event = i_ani_stb & i_animate
//   i_x1, i_x2            ball left / right edge (12-bit)
//   i_y1, i_y2            ball top / bottom edge (12-bit)
//   i_clear               restore all bricks and return to idle
//   i_col_detected        per-brick consumed flags from the ball block
//   o_hit_block           2-bit code per brick, brick k on [2k+1:2k]
//   o_alive               per-brick present flags
//   o_busy                scan in progress
//   o_all_clear           no bricks alive (registered, one cycle behind o_alive)
//   o_overrun             one-cycle pulse when a frame event arrives mid-scan
module brick_field #(
  parameter int X0  = 16,
  parameter int Y0  = 32,
  parameter int BW  = 52,
  parameter int BH  = 16,
  parameter int GAP = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic [11:0] i_x1,
  input  logic [11:0] i_x2,
  input  logic [11:0] i_y1,
  input  logic [11:0] i_y2,
  input  logic        i_clear,
  input  logic [21:0] i_col_detected,
  output logic [43:0] o_hit_block,
  output logic [21:0] o_alive,
  output logic        o_busy,
  output logic        o_all_clear,
  output logic        o_overrun
);

  localparam logic [11:0] X0_V   = 12'(X0);
  localparam logic [11:0] Y0_V   = 12'(Y0);
  localparam logic [11:0] STEP_X = 12'(BW + GAP);
  localparam logic [11:0] STEP_Y = 12'(BH + GAP);
  localparam logic [11:0] BW_M1  = 12'(BW - 1);
  localparam logic [11:0] BH_M1  = 12'(BH - 1);
  localparam logic [4:0]  LAST_IDX = 5'd21;
  localparam logic [3:0]  LAST_COL = 4'd10;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [3:0]  col;
  logic [11:0] bx1, by1, bx2, by2;
  logic [11:0] lx1, lx2, ly1, ly2;
  logic [43:0] shadow;
  logic        found;
  logic        copy_pending;

  logic        frame_evt;
  logic        start;
  logic        in_scan;
  logic        last;
  logic        overlap;
  logic [11:0] dx_a, dx_b, dy_a, dy_b, px, py;
  logic [1:0]  code;
  logic [21:0] hit_mask;

  assign frame_evt = i_ani_stb & i_animate;
  assign in_scan   = (state == SCAN);
  assign last      = in_scan && (idx == LAST_IDX);
  // The cycle spent copying the shadow into o_hit_block still counts as busy,
  // so a new scan may only start once that copy has landed.
  assign start     = frame_evt && ((state == IDLE) || ((state == HOLD) && !copy_pending));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) state <= IDLE;
    else                  state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_evt) state_nxt = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nxt = HOLD;
      HOLD:    if (frame_evt && !copy_pending) state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_busy = in_scan | copy_pending;
  end

  // ---------------- brick geometry and collision test ----------------
  assign bx2 = bx1 + BW_M1;
  assign by2 = by1 + BH_M1;

  assign overlap = o_alive[idx] && (lx1 <= bx2) && (lx2 >= bx1) &&
                   (ly1 <= by2) && (ly2 >= by1);

  // Differences wrap when there is no overlap; they are only used when overlap holds.
  assign dx_a = lx2 - bx1;
  assign dx_b = bx2 - lx1;
  assign dy_a = ly2 - by1;
  assign dy_b = by2 - ly1;
  assign px   = (dx_a < dx_b) ? dx_a : dx_b;
  assign py   = (dy_a < dy_b) ? dy_a : dy_b;

  always_comb begin
    code = 2'b11;
    if (py < px)      code = 2'b01;
    else if (px < py) code = 2'b10;
  end

  always_comb begin
    hit_mask = '0;
    for (int k = 0; k < 22; k++) hit_mask[k] = |o_hit_block[2*k +: 2];
  end

  // ---------------- datapath ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx          <= '0;
      col          <= '0;
      bx1          <= '0;
      by1          <= '0;
      lx1          <= '0;
      lx2          <= '0;
      ly1          <= '0;
      ly2          <= '0;
      shadow       <= '0;
      found        <= 1'b0;
      copy_pending <= 1'b0;
      o_alive      <= 22'h3FFFFF;
      o_hit_block  <= '0;
      o_overrun    <= 1'b0;
      o_all_clear  <= 1'b0;
    end else if (i_clear) begin
      idx          <= '0;
      copy_pending <= 1'b0;
      found        <= 1'b0;
      o_alive      <= 22'h3FFFFF;
      o_hit_block  <= '0;
      o_overrun    <= 1'b0;
      o_all_clear  <= (o_alive == '0);
    end else begin
      o_overrun   <= frame_evt & o_busy;
      o_all_clear <= (o_alive == '0);
      // A presented code is consumed by the frame event that observes it.
      o_alive     <= o_alive & ~i_col_detected & ~(frame_evt ? hit_mask : 22'h0);

      if (start) begin
        lx1         <= i_x1;
        lx2         <= i_x2;
        ly1         <= i_y1;
        ly2         <= i_y2;
        idx         <= '0;
        col         <= '0;
        bx1         <= X0_V;
        by1         <= Y0_V;
        shadow      <= '0;
        found       <= 1'b0;
        o_hit_block <= '0;
      end else if (in_scan) begin
        if (overlap && !found) begin
          shadow[{idx, 1'b0} +: 2] <= code;
          found                    <= 1'b1;
        end
        idx          <= last ? 5'd0 : idx + 5'd1;
        copy_pending <= last;
        if (col == LAST_COL) begin
          col <= '0;
          bx1 <= X0_V;
          by1 <= by1 + STEP_Y;
        end else begin
          col <= col + 4'd1;
          bx1 <= bx1 + STEP_X;
        end
      end else if (copy_pending) begin
        o_hit_block  <= shadow;
        copy_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// tb/tb_brick_field.sv - Directed self-checking bench for brick_field.
module tb_brick_field;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_ani_stb = 1'b0;
  logic        i_animate = 1'b0;
  logic [11:0] i_x1 = '0, i_x2 = '0, i_y1 = '0, i_y2 = '0;
  logic        i_clear = 1'b0;
  logic [21:0] i_col_detected = '0;
  logic [43:0] o_hit_block;
  logic [21:0] o_alive;
  logic        o_busy, o_all_clear, o_overrun;

  int n_cmp = 0;
  int n_err = 0;

  brick_field dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_x1(i_x1), .i_x2(i_x2), .i_y1(i_y1), .i_y2(i_y2),
    .i_clear(i_clear), .i_col_detected(i_col_detected),
    .o_hit_block(o_hit_block), .o_alive(o_alive), .o_busy(o_busy),
    .o_all_clear(o_all_clear), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ball(input int x1, input int x2, input int y1, input int y2);
    i_x1 = 12'(x1); i_x2 = 12'(x2); i_y1 = 12'(y1); i_y2 = 12'(y2);
  endtask

  task automatic frame();
    i_ani_stb = 1'b1;
    i_animate = 1'b1;
    tick();
    i_ani_stb = 1'b0;
    i_animate = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      tick();
      n++;
    end
    check("scan_terminates", 64'(o_busy), 64'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset state
    do_reset();
    check("rst_alive", 64'(o_alive), 64'h3FFFFF);
    check("rst_hit", 64'(o_hit_block), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_overrun", 64'(o_overrun), 64'd0);
    check("rst_all_clear", 64'(o_all_clear), 64'd0);

    // Strobe without animate is not a frame event
    i_ani_stb = 1'b1;
    tick();
    i_ani_stb = 1'b0;
    check("no_animate_idle", 64'(o_busy), 64'd0);

    // Brick 0 from below: px=23 py=7 -> vertical bounce
    set_ball(30, 39, 40, 49);
    frame();
    cnt = 0;
    if (o_busy) cnt = 1;
    for (int i = 0; i < 40 && o_busy; i++) begin
      tick();
      if (o_busy) cnt++;
    end
    check("busy_cycles", 64'(cnt), 64'd23);
    check("hit_b0_vertical", 64'(o_hit_block), 64'h1);
    repeat (5) tick();
    check("hit_held", 64'(o_hit_block), 64'h1);
    i_ani_stb = 1'b1; i_animate = 1'b1;
    #1;
    check("hit_held_event_cycle", 64'(o_hit_block), 64'h1);
    tick();
    i_ani_stb = 1'b0; i_animate = 1'b0;
    check("hit_cleared_after_event", 64'(o_hit_block), 64'd0);
    check("alive0_consumed", 64'(o_alive), 64'h3FFFFE);
    wait_done();
    check("dead_brick_no_hit", 64'(o_hit_block), 64'd0);

    // Side hit on brick 0: px=5 py=11 -> horizontal bounce
    do_reset();
    set_ball(62, 71, 36, 45);
    frame();
    wait_done();
    check("hit_b0_horizontal", 64'(o_hit_block), 64'h2);

    // Corner on brick 11: px=py=3
    set_ball(10, 19, 64, 73);
    frame();
    check("alive0_after_horiz", 64'(o_alive), 64'h3FFFFE);
    wait_done();
    check("hit_b11_corner", 64'(o_hit_block), 64'hC00000);

    // Overlap of bricks 0 and 11: lowest index wins
    do_reset();
    set_ball(30, 39, 44, 53);
    frame();
    wait_done();
    check("hit_b0_only", 64'(o_hit_block), 64'h1);
    set_ball(1000, 1009, 1000, 1009);
    frame();
    check("alive11_kept", 64'(o_alive), 64'h3FFFFE);
    wait_done();
    check("far_ball_no_hit", 64'(o_hit_block), 64'd0);

    // Frame event 10 cycles into a scan
    do_reset();
    set_ball(30, 39, 40, 49);
    frame();
    repeat (9) tick();
    set_ball(1000, 1009, 1000, 1009);
    frame();
    check("overrun_pulse", 64'(o_overrun), 64'd1);
    check("busy_during_overrun", 64'(o_busy), 64'd1);
    tick();
    check("overrun_one_cycle", 64'(o_overrun), 64'd0);
    wait_done();
    check("overrun_result_kept", 64'(o_hit_block), 64'h1);

    // Reset at scan index 7
    do_reset();
    set_ball(30, 39, 40, 49);
    frame();
    repeat (7) tick();
    check("midscan_busy", 64'(o_busy), 64'd1);
    do_reset();
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_hit", 64'(o_hit_block), 64'd0);
    check("midrst_alive", 64'(o_alive), 64'h3FFFFF);
    repeat (30) tick();
    check("midrst_no_late_hit", 64'(o_hit_block), 64'd0);
    check("midrst_still_idle", 64'(o_busy), 64'd0);

    // Clear every brick through i_col_detected, then restore with i_clear
    i_col_detected = 22'h3FFFFF;
    tick();
    i_col_detected = '0;
    check("col_all_dead", 64'(o_alive), 64'd0);
    check("all_clear_lag", 64'(o_all_clear), 64'd0);
    tick();
    check("all_clear_set", 64'(o_all_clear), 64'd1);
    i_clear = 1'b1;
    i_col_detected = 22'h3FFFFF;
    tick();
    i_clear = 1'b0;
    i_col_detected = '0;
    check("clear_restores_alive", 64'(o_alive), 64'h3FFFFF);
    check("clear_hit_zero", 64'(o_hit_block), 64'd0);
    tick();
    check("all_clear_dropped", 64'(o_all_clear), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
